// File: rtl/iir_cascade_sequencer.sv
// Time-multiplexes one external stateless biquad datapath across NUM_SECTIONS
// cascaded sections; owns coefficient banks and per-section x/y history.
module iir_cascade_sequencer #(
  parameter int NUM_SECTIONS = 4,
  parameter int DATA_W       = 16,
  parameter int COEF_W       = 18,
  parameter int TIMEOUT      = 15,
  localparam int SEC_W       = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1
) (
  input  logic                      clk,
  input  logic                      i_rst_n,
  input  logic                      i_valid,
  input  logic signed [DATA_W-1:0]  i_sample,
  output logic                      o_ready,
  output logic                      o_valid,
  output logic signed [DATA_W-1:0]  o_sample,
  input  logic                      cfg_we,
  input  logic [SEC_W-1:0]          cfg_sec,
  input  logic [2:0]                cfg_idx,
  input  logic signed [COEF_W-1:0]  cfg_data,
  output logic                      cfg_ready,
  input  logic [NUM_SECTIONS-1:0]   sec_en,
  input  logic                      hist_clr,
  output logic                      dp_start,
  output logic signed [DATA_W-1:0]  dp_x,
  output logic signed [DATA_W-1:0]  dp_x1,
  output logic signed [DATA_W-1:0]  dp_x2,
  output logic signed [DATA_W-1:0]  dp_y1,
  output logic signed [DATA_W-1:0]  dp_y2,
  output logic signed [COEF_W-1:0]  dp_b1,
  output logic signed [COEF_W-1:0]  dp_b2,
  output logic signed [COEF_W-1:0]  dp_b3,
  output logic signed [COEF_W-1:0]  dp_a2,
  output logic signed [COEF_W-1:0]  dp_a3,
  input  logic signed [DATA_W-1:0]  dp_result,
  input  logic                      dp_valid,
  output logic                      o_err
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [SEC_W-1:0] LAST_SEC = SEC_W'(NUM_SECTIONS - 1);
  localparam logic signed [COEF_W-1:0] COEF_UNITY = COEF_W'(32'h10000);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_e;

  state_e                     state_q, state_d;
  logic [SEC_W-1:0]           sec_q, sec_d;
  logic signed [DATA_W-1:0]   cur_q, cur_d;
  logic signed [DATA_W-1:0]   out_q, out_d;
  logic [TMO_W-1:0]           tmo_q, tmo_d;
  logic                       err_q, err_d;

  logic signed [DATA_W-1:0]   x1_q [NUM_SECTIONS];
  logic signed [DATA_W-1:0]   x2_q [NUM_SECTIONS];
  logic signed [DATA_W-1:0]   y1_q [NUM_SECTIONS];
  logic signed [DATA_W-1:0]   y2_q [NUM_SECTIONS];
  // Coefficient slots per section in cfg_idx order: b1, b2, b3, a2, a3.
  logic signed [COEF_W-1:0]   coef_q [NUM_SECTIONS][5];

  logic hist_clr_en, capture_en, cfg_wr_en, opnd_en;

  always_comb begin
    state_d     = state_q;
    sec_d       = sec_q;
    cur_d       = cur_q;
    out_d       = out_q;
    tmo_d       = tmo_q;
    err_d       = err_q;
    o_ready     = 1'b0;
    cfg_ready   = 1'b0;
    o_valid     = 1'b0;
    dp_start    = 1'b0;
    hist_clr_en = 1'b0;
    capture_en  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        o_ready   = !hist_clr;
        cfg_ready = !hist_clr;
        if (hist_clr) begin
          hist_clr_en = 1'b1;
          err_d       = 1'b0;
        end else if (i_valid) begin
          cur_d   = i_sample;
          sec_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tmo_d = '0;
        if (sec_en[sec_q]) begin
          dp_start = 1'b1;
          state_d  = S_WAIT;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_WAIT: begin
        if (dp_valid) begin
          capture_en = 1'b1;
          cur_d      = dp_result;
          state_d    = S_NEXT;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_NEXT: begin
        if (sec_q == LAST_SEC) begin
          out_d   = cur_q;
          state_d = S_DONE;
        end else begin
          sec_d   = sec_q + 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_DONE: begin
        o_valid = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cfg_wr_en = cfg_we && cfg_ready && (cfg_idx <= 3'd4) &&
                     (int'(cfg_sec) < NUM_SECTIONS);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      sec_q   <= '0;
      cur_q   <= '0;
      out_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      cur_q   <= cur_d;
      out_q   <= out_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  // A timed-out section never reaches capture_en, so its history stays intact.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < NUM_SECTIONS; s++) begin
        x1_q[s]      <= '0;
        x2_q[s]      <= '0;
        y1_q[s]      <= '0;
        y2_q[s]      <= '0;
        coef_q[s][0] <= COEF_UNITY;
        for (int c = 1; c < 5; c++) begin
          coef_q[s][c] <= '0;
        end
      end
    end else begin
      if (hist_clr_en) begin
        for (int s = 0; s < NUM_SECTIONS; s++) begin
          x1_q[s] <= '0;
          x2_q[s] <= '0;
          y1_q[s] <= '0;
          y2_q[s] <= '0;
        end
      end else if (capture_en) begin
        x2_q[sec_q] <= x1_q[sec_q];
        x1_q[sec_q] <= cur_q;
        y2_q[sec_q] <= y1_q[sec_q];
        y1_q[sec_q] <= dp_result;
      end
      if (cfg_wr_en) begin
        coef_q[cfg_sec][cfg_idx] <= cfg_data;
      end
    end
  end

  assign opnd_en = (state_q == S_ISSUE) || (state_q == S_WAIT);

  assign dp_x  = opnd_en ? cur_q             : '0;
  assign dp_x1 = opnd_en ? x1_q[sec_q]       : '0;
  assign dp_x2 = opnd_en ? x2_q[sec_q]       : '0;
  assign dp_y1 = opnd_en ? y1_q[sec_q]       : '0;
  assign dp_y2 = opnd_en ? y2_q[sec_q]       : '0;
  assign dp_b1 = opnd_en ? coef_q[sec_q][0]  : '0;
  assign dp_b2 = opnd_en ? coef_q[sec_q][1]  : '0;
  assign dp_b3 = opnd_en ? coef_q[sec_q][2]  : '0;
  assign dp_a2 = opnd_en ? coef_q[sec_q][3]  : '0;
  assign dp_a3 = opnd_en ? coef_q[sec_q][4]  : '0;

  assign o_sample = out_q;
  assign o_err    = err_q;

endmodule
